// File: rtl/taitosj_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : taitosj_pkg
//  Description : Shared types and constants for the Taito SJ hiscore RAM
//                arbiter (state encoding, default pause guard interval).
//  Revision    : 1.0 - initial release
// ============================================================================
package taitosj_pkg;

    // Arbiter states, explicitly encoded in two bits
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        GRANT   = 2'd2,
        RELEASE = 2'd3
    } hs_arb_state_t;

    // Default number of cycles the CPU pause is held after hiscore access ends
    localparam int HS_GUARD_DEFAULT = 4;

    // Width of the guard counter (GUARD is limited to 1..15)
    localparam int HS_GUARD_W = 4;

endpackage
`default_nettype wire

// File: rtl/taitosj_hs_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : taitosj_hs_ram_arbiter
//  Description : Shares the main-CPU work RAM port between the Z80 bus and
//                the hiscore save/restore engine. The hiscore side only gets
//                the RAM mux after the CPU confirms it is halted; the pause is
//                held for a guard interval after the hiscore side lets go.
//  Revision    : 1.0 - initial release
// ============================================================================
module taitosj_hs_ram_arbiter
    import taitosj_pkg::*;
#(
    parameter int AW    = 16,
    parameter int DW    = 8,
    parameter int GUARD = HS_GUARD_DEFAULT
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_din,
    input  logic          cpu_we,
    output logic [DW-1:0] cpu_dout,
    input  logic          cpu_halted,
    output logic          pause_req,
    input  logic [AW-1:0] hs_address,
    input  logic [DW-1:0] hs_data_in,
    input  logic          hs_write,
    input  logic          hs_access_read,
    input  logic          hs_access_write,
    output logic [DW-1:0] hs_data_out,
    output logic          hs_granted,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    output logic          ram_we,
    input  logic [DW-1:0] ram_dout
);

    // Value loaded into the guard counter on entry to RELEASE; the counter
    // then counts GUARD-1 .. 0, giving GUARD cycles of held pause.
    localparam logic [HS_GUARD_W-1:0] c_guard_load = HS_GUARD_W'(GUARD - 1);

    hs_arb_state_t         r_state;
    hs_arb_state_t         w_state_next;
    logic [HS_GUARD_W-1:0] r_guard_cnt;
    logic [HS_GUARD_W-1:0] w_guard_next;
    logic                  r_pause_req;
    logic                  r_hs_granted;
    logic                  r_granted_d1;
    logic [DW-1:0]         r_hs_data_out;
    logic                  w_intent;

    assign w_intent    = hs_access_read | hs_access_write;
    assign pause_req   = r_pause_req;
    assign hs_granted  = r_hs_granted;
    assign hs_data_out = r_hs_data_out;
    assign cpu_dout    = ram_dout;

    // Next-state and guard counter logic
    always_comb begin
        w_state_next = r_state;
        w_guard_next = r_guard_cnt;
        case (r_state)
            IDLE: begin
                if (w_intent) begin
                    w_state_next = REQ;
                end
            end
            REQ: begin
                // Losing intent wins over a simultaneous halt: no grant
                if (!w_intent) begin
                    w_state_next = RELEASE;
                    w_guard_next = c_guard_load;
                end else if (cpu_halted) begin
                    w_state_next = GRANT;
                end
            end
            GRANT: begin
                // A halt that drops here is tolerated; access runs to completion
                if (!w_intent) begin
                    w_state_next = RELEASE;
                    w_guard_next = c_guard_load;
                end
            end
            RELEASE: begin
                // Saturating decrement so the counter never wraps
                if (r_guard_cnt != '0) begin
                    w_guard_next = r_guard_cnt - 1'b1;
                end
                // Re-request goes back through REQ so the halt is re-confirmed
                if (w_intent) begin
                    w_state_next = REQ;
                end else if (r_guard_cnt == '0) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // State, guard counter, registered handshake outputs and hiscore read data
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state       <= IDLE;
            r_guard_cnt   <= '0;
            r_pause_req   <= 1'b0;
            r_hs_granted  <= 1'b0;
            r_granted_d1  <= 1'b0;
            r_hs_data_out <= '0;
        end else begin
            r_state      <= w_state_next;
            r_guard_cnt  <= w_guard_next;
            r_pause_req  <= (w_state_next != IDLE);
            r_hs_granted <= (w_state_next == GRANT);
            r_granted_d1 <= r_hs_granted;
            // RAM read data for a granted address arrives one cycle later
            if (r_granted_d1) begin
                r_hs_data_out <= ram_dout;
            end
        end
    end

    // RAM port mux, selected purely from registered state
    always_comb begin
        if (r_hs_granted) begin
            ram_addr = hs_address;
            ram_din  = hs_data_in;
            ram_we   = hs_write;
        end else begin
            ram_addr = cpu_addr;
            ram_din  = cpu_din;
            // CPU writes are blocked while the pause is being released
            ram_we   = (r_state == RELEASE) ? 1'b0 : cpu_we;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_taitosj_hs_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_taitosj_hs_ram_arbiter
//  Description : Self-checking bench for taitosj_hs_ram_arbiter: directed
//                scenarios plus randomized traffic against a cycle-count
//                reference model with a shadow RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_taitosj_hs_ram_arbiter;

    localparam int AW    = 16;
    localparam int DW    = 8;
    localparam int GUARD = 4;

    logic          clk_sys = 1'b0;
    logic          reset;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_din;
    logic          cpu_we;
    logic [DW-1:0] cpu_dout;
    logic          cpu_halted;
    logic          pause_req;
    logic [AW-1:0] hs_address;
    logic [DW-1:0] hs_data_in;
    logic          hs_write;
    logic          hs_access_read;
    logic          hs_access_write;
    logic [DW-1:0] hs_data_out;
    logic          hs_granted;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic          ram_we;
    logic [DW-1:0] ram_dout;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk_sys = ~clk_sys;

    taitosj_hs_ram_arbiter #(
        .AW(AW), .DW(DW), .GUARD(GUARD)
    ) dut (
        .clk_sys(clk_sys), .reset(reset),
        .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_we(cpu_we), .cpu_dout(cpu_dout),
        .cpu_halted(cpu_halted), .pause_req(pause_req),
        .hs_address(hs_address), .hs_data_in(hs_data_in), .hs_write(hs_write),
        .hs_access_read(hs_access_read), .hs_access_write(hs_access_write),
        .hs_data_out(hs_data_out), .hs_granted(hs_granted),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
    );

    // Work RAM: synchronous read, one cycle latency, read-before-write
    logic [DW-1:0] mem [0:65535];
    always @(posedge clk_sys) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    task automatic tick();
        @(negedge clk_sys);
    endtask

    task automatic idle_all();
        hs_access_read = 1'b0; hs_access_write = 1'b0; hs_write = 1'b0;
        cpu_we = 1'b0; cpu_halted = 1'b0;
        repeat (GUARD + 3) tick();
    endtask

    // Raise read or write intent with the CPU already halted; wait for grant
    task automatic go_grant(input bit rd);
        int n;
        if (rd) hs_access_read = 1'b1; else hs_access_write = 1'b1;
        cpu_halted = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!hs_granted && n < 8);
        n_vec++; if (hs_granted !== 1'b1) begin n_err++; $display("FAIL go_grant_timeout: got %b want 1", hs_granted); end
    endtask

    task automatic test_reset();
        reset = 1'b1; cpu_we = 1'b1; cpu_addr = 16'hFFF0; cpu_din = 8'h3C; hs_access_read = 1'b1;
        tick(); tick();
        n_vec++; if (pause_req !== 1'b0) begin n_err++; $display("FAIL reset_pause: got %b want 0", pause_req); end
        n_vec++; if (hs_granted !== 1'b0) begin n_err++; $display("FAIL reset_granted: got %b want 0", hs_granted); end
        n_vec++; if (hs_data_out !== 8'h00) begin n_err++; $display("FAIL reset_hs_dout: got %h want 00", hs_data_out); end
        n_vec++; if (ram_we !== 1'b1) begin n_err++; $display("FAIL reset_ram_we: got %b want 1", ram_we); end
        n_vec++; if (ram_addr !== 16'hFFF0) begin n_err++; $display("FAIL reset_ram_addr: got %h want fff0", ram_addr); end
        n_vec++; if (ram_din !== 8'h3C) begin n_err++; $display("FAIL reset_ram_din: got %h want 3c", ram_din); end
        reset = 1'b0; cpu_we = 1'b0; hs_access_read = 1'b0;
        idle_all();
    endtask

    task automatic test_basic_read();
        cpu_addr = 16'h1234; cpu_din = 8'h5A; cpu_we = 1'b1;
        tick();
        cpu_we = 1'b0; cpu_addr = 16'h0000;
        hs_address = 16'h1234; hs_access_read = 1'b1;
        tick();
        n_vec++; if (pause_req !== 1'b1) begin n_err++; $display("FAIL basic_pause_lat: got %b want 1", pause_req); end
        repeat (3) begin
            n_vec++; if (hs_granted !== 1'b0) begin n_err++; $display("FAIL basic_early_grant: got %b want 0", hs_granted); end
            tick();
        end
        cpu_halted = 1'b1;
        tick();
        n_vec++; if (hs_granted !== 1'b1) begin n_err++; $display("FAIL basic_grant_lat: got %b want 1", hs_granted); end
        tick();
        n_vec++; if (cpu_dout !== 8'h5A) begin n_err++; $display("FAIL basic_cpu_dout: got %h want 5a", cpu_dout); end
        n_vec++; if (hs_data_out !== 8'h00) begin n_err++; $display("FAIL basic_hs_dout_early: got %h want 00", hs_data_out); end
        tick();
        n_vec++; if (hs_data_out !== 8'h5A) begin n_err++; $display("FAIL basic_hs_dout: got %h want 5a", hs_data_out); end
        idle_all();
    endtask

    task automatic test_write_blocking();
        hs_access_write = 1'b1;
        tick();
        n_vec++; if (pause_req !== 1'b1 || hs_granted !== 1'b0) begin n_err++; $display("FAIL wb_req: got pause %b grant %b want 1 0", pause_req, hs_granted); end
        cpu_addr = 16'h0010; cpu_din = 8'hAA; cpu_we = 1'b1;
        hs_address = 16'h0010; hs_data_in = 8'h55; hs_write = 1'b1;
        #1;
        n_vec++; if (ram_we !== 1'b1 || ram_din !== 8'hAA || ram_addr !== 16'h0010) begin n_err++; $display("FAIL wb_req_cpu_path: got we %b din %h addr %h want 1 aa 0010", ram_we, ram_din, ram_addr); end
        tick();
        cpu_we = 1'b0; hs_write = 1'b0;
        n_vec++; if (mem[16'h0010] !== 8'hAA) begin n_err++; $display("FAIL wb_req_write: got %h want aa", mem[16'h0010]); end
        cpu_halted = 1'b1;
        tick();
        n_vec++; if (hs_granted !== 1'b1) begin n_err++; $display("FAIL wb_grant: got %b want 1", hs_granted); end
        hs_data_in = 8'h77; hs_write = 1'b1;
        tick();
        hs_write = 1'b0; cpu_we = 1'b1; cpu_din = 8'hAA; cpu_addr = 16'h0010;
        #1;
        n_vec++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL wb_cpu_we_in_grant: got %b want 0", ram_we); end
        tick();
        cpu_we = 1'b0;
        n_vec++; if (mem[16'h0010] !== 8'h77) begin n_err++; $display("FAIL wb_final: got %h want 77", mem[16'h0010]); end
        idle_all();
    endtask

    task automatic test_release_guard();
        go_grant(1'b1);
        hs_access_read = 1'b0;
        cpu_we = 1'b1; cpu_addr = 16'hFFF0; cpu_din = 8'h11;
        for (int k = 1; k <= GUARD + 1; k++) begin
            tick();
            if (k == 1) begin
                n_vec++; if (hs_granted !== 1'b0) begin n_err++; $display("FAIL rel_granted_drop: got %b want 0", hs_granted); end
            end
            n_vec++; if (pause_req !== (k <= GUARD)) begin n_err++; $display("FAIL rel_pause_k%0d: got %b want %b", k, pause_req, (k <= GUARD)); end
            n_vec++; if (ram_we !== (k > GUARD)) begin n_err++; $display("FAIL rel_ram_we_k%0d: got %b want %b", k, ram_we, (k > GUARD)); end
        end
        idle_all();
    endtask

    task automatic test_re_request();
        go_grant(1'b1);
        hs_access_read = 1'b0; cpu_halted = 1'b0;
        tick(); tick();
        n_vec++; if (pause_req !== 1'b1 || hs_granted !== 1'b0) begin n_err++; $display("FAIL rr_release: got pause %b grant %b want 1 0", pause_req, hs_granted); end
        hs_access_read = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_vec++; if (pause_req !== 1'b1 || hs_granted !== 1'b0) begin n_err++; $display("FAIL rr_wait_k%0d: got pause %b grant %b want 1 0", k, pause_req, hs_granted); end
        end
        cpu_halted = 1'b1;
        tick();
        n_vec++; if (pause_req !== 1'b1 || hs_granted !== 1'b1) begin n_err++; $display("FAIL rr_regrant: got pause %b grant %b want 1 1", pause_req, hs_granted); end
        idle_all();
    endtask

    task automatic test_abort(input bit halt_same_edge);
        hs_access_write = 1'b1; cpu_halted = 1'b0;
        tick();
        n_vec++; if (pause_req !== 1'b1 || hs_granted !== 1'b0) begin n_err++; $display("FAIL abort_req: got pause %b grant %b want 1 0", pause_req, hs_granted); end
        hs_access_write = 1'b0; cpu_halted = halt_same_edge;
        for (int k = 1; k <= GUARD + 1; k++) begin
            tick();
            n_vec++; if (hs_granted !== 1'b0) begin n_err++; $display("FAIL abort_grant_h%0d_k%0d: got %b want 0", halt_same_edge, k, hs_granted); end
            n_vec++; if (pause_req !== (k <= GUARD)) begin n_err++; $display("FAIL abort_pause_h%0d_k%0d: got %b want %b", halt_same_edge, k, pause_req, (k <= GUARD)); end
        end
        idle_all();
    endtask

    task automatic test_reset_mid_grant();
        hs_address = 16'h1234;
        go_grant(1'b1);
        tick(); tick();
        n_vec++; if (hs_data_out !== 8'h5A) begin n_err++; $display("FAIL rmg_pre_dout: got %h want 5a", hs_data_out); end
        reset = 1'b1; cpu_we = 1'b1; cpu_addr = 16'hFFF1; cpu_din = 8'h22;
        tick();
        n_vec++; if (pause_req !== 1'b0) begin n_err++; $display("FAIL rmg_pause: got %b want 0", pause_req); end
        n_vec++; if (hs_granted !== 1'b0) begin n_err++; $display("FAIL rmg_granted: got %b want 0", hs_granted); end
        n_vec++; if (hs_data_out !== 8'h00) begin n_err++; $display("FAIL rmg_hs_dout: got %h want 00", hs_data_out); end
        n_vec++; if (ram_we !== 1'b1 || ram_addr !== 16'hFFF1) begin n_err++; $display("FAIL rmg_cpu_mux: got we %b addr %h want 1 fff1", ram_we, ram_addr); end
        reset = 1'b0;
        idle_all();
    endtask

    // Randomized traffic against a model that tracks pause/grant by counting
    // remaining guard cycles and mirrors RAM contents in a shadow array.
    task automatic test_random();
        logic [7:0]  sh [0:15];
        bit          m_pause, m_grant, m_gprev, intent;
        int          m_rel;
        logic [7:0]  m_rd, m_dout, e_din;
        logic [15:0] e_addr;
        logic        e_we;
        m_pause = 0; m_grant = 0; m_gprev = 0; m_rel = 0; m_rd = '0; m_dout = '0;
        for (int c = 0; c < 700; c++) begin
            @(negedge clk_sys);
            if (c < 2) begin
                reset = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0100;
                hs_access_read = 1'b0; hs_access_write = 1'b0; hs_write = 1'b0; cpu_halted = 1'b0;
                hs_address = 16'h0100;
            end else if (c < 18) begin
                reset = 1'b0; cpu_we = 1'b1;
                cpu_addr = 16'h0100 | 16'(c - 2); cpu_din = 8'($urandom);
            end else begin
                reset = ($urandom_range(0, 63) == 0);
                if ($urandom_range(0, 5) == 0) begin
                    if (hs_access_read | hs_access_write) {hs_access_read, hs_access_write} = 2'b00;
                    else {hs_access_read, hs_access_write} = 2'($urandom_range(1, 3));
                end
                if ($urandom_range(0, 3) == 0) cpu_halted = ~cpu_halted;
                cpu_we     = ($urandom_range(0, 2) == 0);
                hs_write   = ($urandom_range(0, 2) == 0);
                cpu_addr   = 16'h0100 | 16'($urandom_range(0, 15));
                hs_address = 16'h0100 | 16'($urandom_range(0, 15));
                cpu_din    = 8'($urandom);
                hs_data_in = 8'($urandom);
            end
            #1;
            intent = hs_access_read | hs_access_write;
            e_addr = m_grant ? hs_address : cpu_addr;
            e_din  = m_grant ? hs_data_in : cpu_din;
            e_we   = m_grant ? hs_write : ((m_rel > 0) ? 1'b0 : cpu_we);
            if (c >= 1) begin
                n_vec++; if (pause_req !== m_pause) begin n_err++; $display("FAIL rnd_pause c%0d: got %b want %b", c, pause_req, m_pause); end
                n_vec++; if (hs_granted !== m_grant) begin n_err++; $display("FAIL rnd_granted c%0d: got %b want %b", c, hs_granted, m_grant); end
                n_vec++; if (ram_addr !== e_addr) begin n_err++; $display("FAIL rnd_ram_addr c%0d: got %h want %h", c, ram_addr, e_addr); end
                n_vec++; if (ram_din !== e_din) begin n_err++; $display("FAIL rnd_ram_din c%0d: got %h want %h", c, ram_din, e_din); end
                n_vec++; if (ram_we !== e_we) begin n_err++; $display("FAIL rnd_ram_we c%0d: got %b want %b", c, ram_we, e_we); end
                n_vec++; if (hs_data_out !== m_dout) begin n_err++; $display("FAIL rnd_hs_dout c%0d: got %h want %h", c, hs_data_out, m_dout); end
            end
            if (c >= 19) begin
                n_vec++; if (cpu_dout !== m_rd) begin n_err++; $display("FAIL rnd_cpu_dout c%0d: got %h want %h", c, cpu_dout, m_rd); end
            end
            // Advance the model across the coming clock edge
            if (reset) m_dout = '0;
            else if (m_gprev) m_dout = m_rd;
            m_rd = sh[e_addr[3:0]];
            if (e_we) sh[e_addr[3:0]] = e_din;
            if (reset) begin
                m_pause = 0; m_grant = 0; m_rel = 0; m_gprev = 0;
            end else begin
                m_gprev = m_grant;
                if (!m_pause) begin
                    if (intent) m_pause = 1;
                end else if (m_grant) begin
                    if (!intent) begin m_grant = 0; m_rel = GUARD; end
                end else if (m_rel > 0) begin
                    if (intent) m_rel = 0;
                    else begin m_rel--; if (m_rel == 0) m_pause = 0; end
                end else begin
                    if (!intent) m_rel = GUARD;
                    else if (cpu_halted) m_grant = 1;
                end
            end
        end
        reset = 1'b0;
        idle_all();
    endtask

    initial begin
        reset = 1'b1; cpu_addr = '0; cpu_din = '0; cpu_we = 1'b0; cpu_halted = 1'b0;
        hs_address = '0; hs_data_in = '0; hs_write = 1'b0;
        hs_access_read = 1'b0; hs_access_write = 1'b0;
        tick();
        test_reset();
        test_basic_read();
        test_write_blocking();
        test_release_guard();
        test_re_request();
        test_abort(1'b0);
        test_abort(1'b1);
        test_reset_mid_grant();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/taitosj_hs_ram_arbiter.md
# taitosj_hs_ram_arbiter

Arbitrates the Taito SJ main-CPU work RAM port between the Z80 bus and the hiscore save/restore engine. The hiscore engine asks for RAM access; the block then requests a CPU pause and waits for the CPU to confirm it is halted. Only then does it switch the RAM address, data and write-enable mux to the hiscore side. When access ends, it holds the pause for a guard interval before releasing it. The block sits in `taitosj_fpga`, between the CPU bus decode, the work RAM instance and the `hs_*` nets from the top level.

## Interface
Parameters:
- `AW`, 16, RAM/hiscore address width
- `DW`, 8, data width
- `GUARD`, 4, cycles pause is held after the hiscore releases (range 1..15)

Ports:
- `clk_sys`  in  1  system clock (32 MHz domain)
- `reset`  in  1  synchronous, active-high reset
- `cpu_addr`  in  AW  CPU address to work RAM
- `cpu_din`  in  DW  CPU write data
- `cpu_we`  in  1  CPU write strobe, qualified by RAM chip-select
- `cpu_dout`  out  DW  RAM read data returned to CPU
- `cpu_halted`  in  1  CPU stopped at a bus boundary, no cycle in flight
- `pause_req`  out  1  request to pause CPU; ORed with the user/OSD pause upstream
- `hs_address`  in  AW  hiscore address
- `hs_data_in`  in  DW  hiscore write data
- `hs_write`  in  1  hiscore write strobe
- `hs_access_read`  in  1  hiscore read intent
- `hs_access_write`  in  1  hiscore write intent
- `hs_data_out`  out  DW  RAM read data to hiscore
- `hs_granted`  out  1  RAM mux currently selects the hiscore side
- `ram_addr`  out  AW  to RAM
- `ram_din`  out  DW  to RAM
- `ram_we`  out  1  to RAM
- `ram_dout`  in  DW  from RAM (synchronous read, 1-cycle latency)

## Operation
- `intent` = `hs_access_read | hs_access_write`.
- States are IDLE, REQ, GRANT and RELEASE:
  - **IDLE**: `pause_req`=0; mux on CPU. If `intent`=1, go to REQ.
  - **REQ**: `pause_req`=1; mux stays on CPU, because the CPU may still be finishing a cycle. If `cpu_halted`=1, go to GRANT. If `intent` drops before the CPU halts, go to RELEASE.
  - **GRANT**: `pause_req`=1; `hs_granted`=1. Mux is on hiscore: `ram_addr`=`hs_address`, `ram_din`=`hs_data_in`, `ram_we`=`hs_write`. If `intent`=0, go to RELEASE and load the guard counter with GUARD-1.
  - **RELEASE**: `pause_req`=1; mux on CPU; `ram_we` is forced to 0. The counter decrements each cycle.
    - If `intent` reasserts, go to REQ. Re-confirm `cpu_halted`; do not jump straight to GRANT.
    - Otherwise go to IDLE when the counter is 0.
- Write blocking:
  - `hs_write` is ignored outside GRANT.
  - `cpu_we` is passed to RAM only in IDLE and REQ.
- Read data:
  - `cpu_dout` = `ram_dout` unconditionally.
  - `hs_data_out` is registered. It captures `ram_dout` every cycle in which `hs_granted` was 1 on the previous cycle, and holds otherwise.
- If `cpu_halted` falls while in GRANT, the block still completes the hiscore access. A pause violation is upstream's responsibility. Verification flags it as an assertion warning, not an error.

## Timing
- Reset values: state IDLE, `pause_req`=0, `hs_granted`=0, `hs_data_out`=0, guard counter 0. The mux selects CPU, so `ram_we`=`cpu_we`.
- Reset asserted in any state returns to IDLE on the next edge. `pause_req` drops that same edge.
- Latency, all in `clk_sys` cycles:
  - `intent` rising to `pause_req`=1: 1.
  - `cpu_halted` sampled 1 in REQ to `hs_granted`=1: 1.
  - Hiscore address at cycle n in GRANT to valid `hs_data_out` at cycle n+2 (RAM latency plus output register).
  - Release: `intent`=0 in GRANT gives `hs_granted`=0 next cycle. `pause_req` stays high GUARD cycles after that, then falls.
- Mux outputs are combinational from the state register. There are no glitches within a cycle relative to the state.
- Simultaneous `intent`=0 and `cpu_halted`=1 in REQ: go to RELEASE; no grant.
- Guard counter width is 4 bits. It must not underflow: stop at 0.

## Structure
- Shared package `taitosj_pkg` holds:
  - `hs_arb_state_t` enum (IDLE, REQ, GRANT, RELEASE)
  - the default `GUARD` constant
- Single module, no sub-module. The guard counter is too small to justify one.

## Test plan
- **Basic read**: pulse `intent` with `hs_access_read`=1 and hold it. Assert `cpu_halted` 3 cycles after `pause_req`. Read addr 0x1234 (preloaded with 0x5A). Required: `pause_req` high 1 cycle after intent, `hs_granted` 1 cycle after halted, `hs_data_out`=0x5A two cycles after the address.
- **Write blocking**: CPU writes 0xAA to 0x0010 while in REQ; the write lands. Hiscore then writes 0x77 to 0x0010 during GRANT. A `cpu_we` asserted during GRANT has no effect. Required: final RAM[0x0010]=0x77.
- **Release guard**: drop `intent` in GRANT with GUARD=4. Required: `hs_granted`=0 next cycle, `pause_req` falls exactly 4 cycles later, and `ram_we` stays 0 throughout RELEASE.
- **Re-request**: reassert `intent` at guard count 2. Required: state goes to REQ, `pause_req` never drops, and GRANT requires `cpu_halted` again.
- **Abort**: `intent` drops in REQ before `cpu_halted`. Required: no `hs_granted` pulse; RELEASE, then IDLE after GUARD cycles.
- **Reset mid-GRANT**: reset during GRANT. Required: next cycle `pause_req`=0, `hs_granted`=0, `hs_data_out`=0, and the CPU drives RAM.
